// File: rtl/switch_allocator.sv
// Per-router switch allocator: round-robin wormhole output arbitration
// with a per-output credit counter mirroring the downstream buffer.
module switch_allocator #(
    parameter int PORT_NUM     = 5,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [PORT_NUM-1:0]                        req_i,
    input  logic [PORT_NUM-1:0][$clog2(PORT_NUM)-1:0]  out_port_i,
    input  logic [PORT_NUM-1:0]                        head_i,
    input  logic [PORT_NUM-1:0]                        tail_i,
    input  logic [PORT_NUM-1:0]                        credit_ret_i,
    output logic [PORT_NUM-1:0]                        grant_o,
    output logic [PORT_NUM-1:0][$clog2(PORT_NUM)-1:0]  xbar_sel_o,
    output logic [PORT_NUM-1:0]                        xbar_valid_o
);

    localparam int PW = $clog2(PORT_NUM);
    localparam int CW = $clog2(BUFFER_DEPTH + 1);

    localparam logic MODE_FREE   = 1'b0;
    localparam logic MODE_LOCKED = 1'b1;

    logic [PORT_NUM-1:0]                mode;
    logic [PORT_NUM-1:0][PW-1:0]        owner;
    logic [PORT_NUM-1:0][PW-1:0]        rr_ptr;
    logic [PORT_NUM-1:0][CW-1:0]        credits;

    logic [PORT_NUM-1:0][PORT_NUM-1:0]  cand;
    logic [PORT_NUM-1:0][PW-1:0]        win;
    logic [PORT_NUM-1:0][PW-1:0]        rr_nxt;
    logic [PORT_NUM-1:0]                hit;
    logic [PORT_NUM-1:0]                gnt;
    logic [PORT_NUM-1:0]                win_tail;
    logic [PW:0]                        sum;
    logic [PW-1:0]                      idx;

    always_comb begin
        cand         = '0;
        win          = '0;
        rr_nxt       = '0;
        hit          = '0;
        gnt          = '0;
        win_tail     = '0;
        sum          = '0;
        idx          = '0;
        grant_o      = '0;
        xbar_sel_o   = '0;
        xbar_valid_o = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                cand[o][i] = req_i[i]
                          && (out_port_i[i] == PW'(o))
                          && (i != o);
            end
            if (mode[o] == MODE_FREE) begin
                // first eligible head at or after rr_ptr, wrapping
                for (int k = 0; k < PORT_NUM; k++) begin
                    sum = {1'b0, rr_ptr[o]} + (PW+1)'(k);
                    if (sum >= (PW+1)'(PORT_NUM)) begin
                        sum = sum - (PW+1)'(PORT_NUM);
                    end
                    idx = sum[PW-1:0];
                    if (!hit[o] && cand[o][idx] && head_i[idx]) begin
                        hit[o] = 1'b1;
                        win[o] = idx;
                    end
                end
            end else begin
                win[o] = owner[o];
                hit[o] = cand[o][owner[o]];
            end
            gnt[o]      = hit[o] && (credits[o] != '0) && !rst;
            win_tail[o] = tail_i[win[o]];
            rr_nxt[o]   = (win[o] == PW'(PORT_NUM - 1)) ? '0
                                                        : win[o] + PW'(1);
            if (gnt[o]) begin
                grant_o[win[o]] = 1'b1;
                xbar_valid_o[o] = 1'b1;
                xbar_sel_o[o]   = win[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode    <= {PORT_NUM{MODE_FREE}};
            owner   <= '0;
            rr_ptr  <= '0;
            for (int o = 0; o < PORT_NUM; o++) begin
                credits[o] <= CW'(BUFFER_DEPTH);
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (gnt[o]) begin
                    if (mode[o] == MODE_FREE) begin
                        rr_ptr[o] <= rr_nxt[o];
                        if (!win_tail[o]) begin
                            mode[o]  <= MODE_LOCKED;
                            owner[o] <= win[o];
                        end
                    end else if (win_tail[o]) begin
                        mode[o] <= MODE_FREE;
                    end
                end
                // grant and return together leave the count unchanged
                if (gnt[o] && !credit_ret_i[o]) begin
                    credits[o] <= credits[o] - CW'(1);
                end else if (!gnt[o] && credit_ret_i[o]) begin
                    if (credits[o] < CW'(BUFFER_DEPTH)) begin
                        credits[o] <= credits[o] + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random wormhole
// traffic, all checked every cycle against a behavioural model.
module tb_switch_allocator;

    localparam int N = 5;
    localparam int D = 8;

    logic            clk;
    logic            rst;
    logic [4:0]      req;
    logic [4:0][2:0] op;
    logic [4:0]      head;
    logic [4:0]      tail;
    logic [4:0]      cret;
    logic [4:0]      gnt;
    logic [4:0][2:0] xs;
    logic [4:0]      xv;

    int total = 0;
    int bad   = 0;

    // model state and expected outputs for the current cycle
    bit              m_lock [N];
    int              m_own  [N];
    int              m_rr   [N];
    int              m_cred [N];
    logic [4:0]      e_gnt;
    logic [4:0]      e_xv;
    logic [4:0][2:0] e_sel;

    // random driver state
    int rem   [N];
    int dst   [N];
    bit first [N];

    switch_allocator #(.PORT_NUM(N), .BUFFER_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .out_port_i   (op),
        .head_i       (head),
        .tail_i       (tail),
        .credit_ret_i (cret),
        .grant_o      (gnt),
        .xbar_sel_o   (xs),
        .xbar_valid_o (xv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int o = 0; o < N; o++) begin
            m_lock[o] = 0;
            m_own[o]  = 0;
            m_rr[o]   = 0;
            m_cred[o] = D;
        end
        e_gnt = '0;
        e_xv  = '0;
        e_sel = '0;
    end

    always @(negedge clk) begin
        e_gnt = '0;
        e_xv  = '0;
        e_sel = '0;
        for (int o = 0; o < N; o++) begin
            int w;
            w = -1;
            if (!rst && m_cred[o] > 0) begin
                if (m_lock[o]) begin
                    if (req[m_own[o]] && op[m_own[o]] == o && m_own[o] != o)
                        w = m_own[o];
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (m_rr[o] + k) % N;
                        if (w < 0 && req[i] && op[i] == o && i != o && head[i])
                            w = i;
                    end
                end
            end
            if (w >= 0) begin
                e_gnt[w] = 1'b1;
                e_xv[o]  = 1'b1;
                e_sel[o] = 3'(w);
            end
        end
        chk("grant", int'(gnt), int'(e_gnt));
        chk("xbar_valid", int'(xv), int'(e_xv));
        chk("xbar_sel", int'(xs), int'(e_sel));
    end

    always @(posedge clk) begin
        for (int o = 0; o < N; o++) begin
            if (rst) begin
                m_lock[o] = 0;
                m_own[o]  = 0;
                m_rr[o]   = 0;
                m_cred[o] = D;
            end else begin
                if (e_xv[o]) begin
                    int w;
                    w = int'(e_sel[o]);
                    if (!m_lock[o]) begin
                        m_rr[o] = (w + 1) % N;
                        if (!tail[w]) begin
                            m_lock[o] = 1;
                            m_own[o]  = w;
                        end
                    end else if (tail[w]) begin
                        m_lock[o] = 0;
                    end
                end
                if (cret[o] && !e_xv[o])
                    m_cred[o] = (m_cred[o] < D) ? m_cred[o] + 1 : D;
                else if (!cret[o] && e_xv[o])
                    m_cred[o] = m_cred[o] - 1;
            end
        end
    end

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req  = '0;
        head = '0;
        tail = '0;
        cret = '0;
        op   = '0;
    endtask

    task automatic do_reset(input int cycles, input logic [4:0] reqv);
        rst  = 1'b1;
        req  = reqv;
        head = '1;
        tail = '1;
        cret = '0;
        for (int i = 0; i < N; i++) op[i] = 3'd3;
        for (int c = 0; c < cycles; c++) begin
            look();
            chk("rst_grant", int'(gnt), 0);
            chk("rst_valid", int'(xv), 0);
            next();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic rand_drive();
        int r;
        for (int i = 0; i < N; i++) begin
            if (e_gnt[i] && rem[i] > 0) begin
                rem[i]--;
                first[i] = 0;
            end
            if (rem[i] == 0 && $urandom_range(0, 1) == 1) begin
                r        = int'($urandom_range(0, 3));
                dst[i]   = (r >= i) ? r + 1 : r;
                rem[i]   = int'($urandom_range(1, 4));
                first[i] = 1;
            end
            req[i]  = (rem[i] > 0) && ($urandom_range(0, 7) != 0);
            op[i]   = 3'(dst[i]);
            head[i] = first[i];
            tail[i] = (rem[i] == 1);
        end
        for (int o = 0; o < N; o++) cret[o] = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        int cnt;
        int exp_sel;
        rst = 1'b1;
        idle_inputs();

        // reset with every input requesting, then LOCAL->EAST at once
        do_reset(2, 5'b11111);
        req = 5'b00001; op[0] = 3'd3; head = 5'b00001; tail = 5'b00001;
        look();
        chk("first_grant", int'(gnt), 1);
        chk("first_sel_east", int'(xs[3]), 0);
        chk("first_valid_east", int'(xv[3]), 1);
        next();
        idle_inputs();

        // round-robin NORTH/WEST to LOCAL
        do_reset(1, '0);
        req = 5'b10010; head = 5'b10010; tail = 5'b10010;
        op[1] = 3'd0; op[4] = 3'd0;
        for (int c = 0; c < 4; c++) begin
            exp_sel = (c % 2 == 0) ? 1 : 4;
            look();
            chk("rr_grant", int'(gnt), 1 << exp_sel);
            chk("rr_sel", int'(xs[0]), exp_sel);
            next();
        end
        idle_inputs();

        // wormhole lock: EAST 3-flit to SOUTH, LOCAL head waits
        do_reset(1, '0);
        for (int c = 0; c < 5; c++) begin
            req = '0; head = '0; tail = '0;
            op[3] = 3'd2; op[0] = 3'd2;
            if (c < 3) begin
                req[3]  = 1'b1;
                head[3] = (c == 0);
                tail[3] = (c == 2);
            end
            if (c >= 1 && c < 4) begin
                req[0] = 1'b1; head[0] = 1'b1; tail[0] = 1'b1;
            end
            look();
            if (c < 3) chk("worm_east", int'(gnt[3]), 1);
            if (c >= 1 && c < 4) chk("worm_local", int'(gnt[0]), (c == 3) ? 1 : 0);
            next();
        end
        idle_inputs();

        // credit exhaustion and single-credit return
        do_reset(1, '0);
        req = 5'b00001; op[0] = 3'd3; head = 5'b00001; tail = 5'b00001;
        cnt = 0;
        for (int c = 0; c < 13; c++) begin
            cret = '0;
            if (c == 10) cret[3] = 1'b1;
            look();
            if (gnt[0]) cnt++;
            if (c == 8 || c == 9 || c == 10 || c == 12)
                chk("cred_starved", int'(gnt[0]), 0);
            if (c == 11) chk("cred_return", int'(gnt[0]), 1);
            if (c == 9) chk("cred_count8", cnt, 8);
            next();
        end
        chk("cred_count9", cnt, 9);
        idle_inputs();

        // grant and return together at credits=3
        do_reset(1, '0);
        req = 5'b00001; op[0] = 3'd3; head = 5'b00001; tail = 5'b00001;
        for (int c = 0; c < 5; c++) next();
        cret[3] = 1'b1;
        look();
        chk("simul_grant", int'(gnt[0]), 1);
        next();
        cret = '0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            look();
            if (gnt[0]) cnt++;
            next();
        end
        chk("simul_left", cnt, 3);
        idle_inputs();

        // U-turn never granted; reset mid-packet frees LOCAL
        do_reset(1, '0);
        req = 5'b00010; op[1] = 3'd1; head = 5'b00010; tail = 5'b00010;
        for (int c = 0; c < 3; c++) begin
            look();
            chk("uturn", int'(gnt), 0);
            next();
        end
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            req = 5'b10000; op[4] = 3'd0;
            head = (c == 0) ? 5'b10000 : 5'b00000;
            look();
            chk("west_flit", int'(gnt[4]), 1);
            next();
        end
        rst = 1'b1;
        head = '0;
        look();
        chk("mid_rst", int'(gnt), 0);
        next();
        rst = 1'b0;
        req = 5'b00100; op[2] = 3'd0; op[4] = 3'd0;
        head = 5'b00100; tail = 5'b00100;
        look();
        chk("after_rst_south", int'(gnt), 5'b00100);
        next();
        idle_inputs();

        // random wormhole traffic
        do_reset(1, '0);
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; dst[i] = 0; first[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            rand_drive();
            next();
        end
        idle_inputs();
        look();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router switch allocator and output-credit tracker for the mesh NoC. It sits between the input-port buffers and the crossbar. Each cycle it matches input ports to output ports using the output port already produced by route computation for each input. Output ports are held for the full length of a wormhole packet, granted round-robin between packets, and gated by a per-output credit counter that mirrors the downstream buffer.

## Interface
Parameters:
- PORT_NUM, 5: number of router ports. Port index equals the `inout_Port` value from `params_noc`: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4.
- BUFFER_DEPTH, 8: downstream input-buffer depth in flits. This is the initial and maximum credit count.

Ports (all synchronous to clk):
- clk  in  1  router clock
- rst  in  1  synchronous, active-high reset
- req_i  in  PORT_NUM  per input: a flit is valid at the buffer head
- out_port_i  in  PORT_NUM x inout_Port  per input: requested output, from route computation
- head_i  in  PORT_NUM  per input: flit is a head flit
- tail_i  in  PORT_NUM  per input: flit is a tail flit. Head and tail both set means a single-flit packet.
- credit_ret_i  in  PORT_NUM  per output: downstream freed one buffer slot
- grant_o  out  PORT_NUM  per input: flit is transferred at this clock edge, and the input pops it
- xbar_sel_o  out  PORT_NUM x $clog2(PORT_NUM)  per output: index of the input driving it
- xbar_valid_o  out  PORT_NUM  per output: crossbar carries a flit this cycle

## Operation
- Each output o keeps registered state:
  - mode, FREE or LOCKED
  - owner[$clog2(PORT_NUM)-1:0]
  - rr_ptr, the highest-priority input
  - credits[$clog2(BUFFER_DEPTH+1)-1:0]
- An input i is a candidate for output o when req_i[i]=1 and out_port_i[i]=o and o≠i. A U-turn request is never granted.
- FREE mode:
  - Only candidates with head_i=1 are eligible.
  - Winner: the first eligible input scanning rr_ptr, rr_ptr+1, … mod PORT_NUM.
  - A grant is issued only if credits>0.
  - On a grant, rr_ptr becomes (winner+1) mod PORT_NUM.
  - If the granted flit has tail_i=0, mode becomes LOCKED and owner becomes the winner. A single-flit packet leaves the output FREE.
- LOCKED mode:
  - Only owner is served. Its flit is granted when it is a candidate and credits>0.
  - A head from the owner while LOCKED is a protocol error. It is granted as a body flit; no check is required.
  - A granted flit with tail_i=1 returns the output to FREE. rr_ptr is unchanged.
  - Requests from other inputs wait, including head flits.
- Credits:
  - A grant only: minus 1.
  - credit_ret_i only: plus 1, saturating at BUFFER_DEPTH.
  - Both in the same cycle: unchanged.
  - The counter never wraps below 0, because no grant is issued at 0.
- Each input requests exactly one output, so at most one bit of grant_o is set per output and at most one grant per input per cycle.
- grant_o[i]=1 iff i is the granted input of output out_port_i[i].
- xbar_sel_o[o] is the granted input. When xbar_valid_o[o]=0, xbar_sel_o[o]=0.

## Timing
- Allocation is combinational from registered state and current inputs. A grant is issued in the same cycle as the request; the flit traverses the crossbar in that same cycle.
- mode, owner, rr_ptr and credits update at the rising clk edge of the grant cycle.
- A packet of N flits with continuous req_i and sufficient credits occupies its output for exactly N consecutive cycles.
- The next packet to the same output can be granted in the cycle after the tail grant.
- A credit returned in cycle t can enable a grant in cycle t+1, not in cycle t.
- Reset, taking effect at the first clk edge with rst=1, including mid-packet:
  - all outputs FREE, owner=0, rr_ptr=0, credits=BUFFER_DEPTH
  - grant_o=0, xbar_valid_o=0 and xbar_sel_o=0 while rst=1
  - partially sent packets are abandoned; upstream is reset together with this block

## Test plan
- Reset: hold rst for 2 cycles with req_i=5'b11111 -> grant_o=0 and xbar_valid_o=0 throughout. After release, single-flit LOCAL->EAST is granted on the first cycle.
- Round-robin: NORTH and WEST issue single-flit heads to LOCAL every cycle, starting at rr_ptr=0:
  - grants alternate NORTH, WEST, NORTH…
  - xbar_sel_o[LOCAL] alternates 1, 4
- Wormhole lock:
  - EAST sends a 3-flit packet to SOUTH starting at cycle 0; LOCAL presents a head to SOUTH from cycle 1.
  - Expect grant_o[EAST]=1 in cycles 0–2, and grant_o[LOCAL]=0 until cycle 3, when it becomes 1.
- Credit exhaustion: BUFFER_DEPTH=8, LOCAL sends 10 single-flit packets to EAST with no returns.
  - Expect 8 grants, then grant_o[LOCAL]=0.
  - Pulse credit_ret_i[EAST] at cycle t -> exactly one grant at t+1.
- Simultaneous credit events: at credits=3, grant and credit_ret_i in the same cycle -> credits stay 3. Verify that exactly 3 further grants occur without returns.
- U-turn and reset mid-packet:
  - NORTH requests NORTH -> never granted.
  - Assert rst after flit 2 of a 4-flit WEST->LOCAL packet -> after reset, a new head from SOUTH to LOCAL is granted immediately.
